// File: rtl/vga_text_pkg.sv
// Shared constants for the character-mode pixel generator.
package vga_text_pkg;

    localparam int unsigned LATENCY   = 4;
    localparam int unsigned GLYPH_W   = 8;
    localparam int unsigned GLYPH_H   = 16;
    localparam int unsigned PIX_W     = 11;
    localparam int unsigned RGB_W     = 12;
    localparam int unsigned PAL_IDX_W = 4;
    localparam int unsigned CHAR_W    = 8;
    localparam int unsigned CELL_W    = 16;
    localparam int unsigned FONT_AW   = 12;

    // wr_data / text RAM word layout: {bg, fg, char}
    localparam int unsigned WR_CHAR_LSB = 0;
    localparam int unsigned WR_FG_LSB   = 8;
    localparam int unsigned WR_BG_LSB   = 12;

    // CGA-style 16-colour palette, {R,G,B} nibbles
    localparam logic [RGB_W-1:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage

// File: rtl/vga_font_rom.sv
// 4096x8 glyph ROM addressed by {char_code, glyph_row}, one-cycle read latency.
module vga_font_rom
    import vga_text_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [FONT_AW-1:0] addr_i,
    output logic [GLYPH_W-1:0] data_o
);

    logic [GLYPH_W-1:0] data_q;

    // Built-in glyph table; codes without a glyph render as blank rows.
    function automatic logic [GLYPH_W-1:0] glyph_row(input logic [FONT_AW-1:0] a);
        logic [7:0] code;
        logic [3:0] row;
        logic [7:0] r;
        code = a[FONT_AW-1:4];
        row  = a[3:0];
        r    = '0;
        case (code)
            8'h41: begin
                case (row)
                    4'd2:                    r = 8'h10;
                    4'd3:                    r = 8'h38;
                    4'd4:                    r = 8'h6C;
                    4'd5, 4'd6:              r = 8'hC6;
                    4'd7:                    r = 8'hFE;
                    4'd8, 4'd9, 4'd10, 4'd11: r = 8'hC6;
                    default:                 r = 8'h00;
                endcase
            end
            8'h42: begin
                case (row)
                    4'd2, 4'd11:             r = 8'hFC;
                    4'd3, 4'd4, 4'd5:        r = 8'h66;
                    4'd6:                    r = 8'h7C;
                    4'd7, 4'd8, 4'd9, 4'd10: r = 8'h66;
                    default:                 r = 8'h00;
                endcase
            end
            8'hDB:   r = 8'hFF;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Registered ROM read
    always_ff @(posedge CLK) begin
        if (RESET) data_q <= '0;
        else       data_q <= glyph_row(addr_i);
    end

    assign data_o = data_q;

endmodule

// File: rtl/vga_text_render.sv
// Text-mode pixel generator: cell lookup, glyph fetch, palette, blinking cursor.
module vga_text_render
    import vga_text_pkg::*;
#(
    parameter int unsigned COLS         = 160,
    parameter int unsigned ROWS         = 64,
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hdisp_in,
    input  logic              vdisp_in,
    input  logic [PIX_W-1:0]  hpix_in,
    input  logic [PIX_W-1:0]  vpix_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CELL_W-1:0] wr_data,
    input  logic              cursor_en,
    input  logic [ADDR_W-1:0] cursor_addr,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              de_out,
    output logic [RGB_W-1:0]  rgb_out,
    output logic              frame_tick
);

    localparam int unsigned CELLS   = COLS * ROWS;
    localparam int unsigned COL_W   = $clog2(GLYPH_W);
    localparam int unsigned ROW_W   = $clog2(GLYPH_H);
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CELL_W-1:0]    text_ram [1 << ADDR_W];

    logic [ADDR_W-1:0]    addr_s1_q, addr_s1_d;
    logic [COL_W-1:0]     col_s1_q, col_s2_q, col_s3_q;
    logic [ROW_W-1:0]     row_s1_q, row_s2_q;
    logic                 de_s1_q, de_s2_q, de_s3_q, de_out_q;
    logic                 hit_s2_q, hit_s3_q;
    logic [CELL_W-1:0]    ram_rd_q;
    logic [PAL_IDX_W-1:0] fg_s3_q, bg_s3_q, pal_idx;
    logic [GLYPH_W-1:0]   rom_row;
    logic                 pix;
    logic [RGB_W-1:0]     rgb_q, rgb_d;
    logic [LATENCY-1:0]   hs_dly_q, vs_dly_q;
    logic                 wr_ok;

    logic                 vsync_q, frame_rise, frame_tick_q;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_on_q, blink_on_d;

    // Cell address, colour selection and blink next-state
    always_comb begin
        addr_s1_d   = ADDR_W'(32'(vpix_in[PIX_W-1:ROW_W]) * COLS + 32'(hpix_in[PIX_W-1:COL_W]));
        wr_ok       = wr_en && (32'(wr_addr) < CELLS);
        pix         = rom_row[COL_W'(GLYPH_W - 1) - col_s3_q];
        pal_idx     = (pix ^ hit_s3_q) ? fg_s3_q : bg_s3_q;
        rgb_d       = de_s3_q ? PALETTE[pal_idx] : '0;
        frame_rise  = vsync_in & ~vsync_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_rise) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Text RAM write port; cells beyond the visible grid are dropped
    always_ff @(posedge CLK) begin
        if (wr_ok) text_ram[wr_addr] <= wr_data;
    end

    // Four-stage pixel pipeline plus matching sync delay lines
    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_s1_q <= '0;
            col_s1_q  <= '0;
            row_s1_q  <= '0;
            de_s1_q   <= 1'b0;
            ram_rd_q  <= '0;
            col_s2_q  <= '0;
            row_s2_q  <= '0;
            de_s2_q   <= 1'b0;
            hit_s2_q  <= 1'b0;
            fg_s3_q   <= '0;
            bg_s3_q   <= '0;
            col_s3_q  <= '0;
            de_s3_q   <= 1'b0;
            hit_s3_q  <= 1'b0;
            rgb_q     <= '0;
            de_out_q  <= 1'b0;
            hs_dly_q  <= '0;
            vs_dly_q  <= '0;
        end else begin
            addr_s1_q <= addr_s1_d;
            col_s1_q  <= hpix_in[COL_W-1:0];
            row_s1_q  <= vpix_in[ROW_W-1:0];
            de_s1_q   <= hdisp_in & vdisp_in;
            // Read-first: a same-cycle write to this cell lands after the read
            ram_rd_q  <= text_ram[addr_s1_q];
            col_s2_q  <= col_s1_q;
            row_s2_q  <= row_s1_q;
            de_s2_q   <= de_s1_q;
            hit_s2_q  <= cursor_en & blink_on_q & (addr_s1_q == cursor_addr);
            fg_s3_q   <= ram_rd_q[WR_FG_LSB +: PAL_IDX_W];
            bg_s3_q   <= ram_rd_q[WR_BG_LSB +: PAL_IDX_W];
            col_s3_q  <= col_s2_q;
            de_s3_q   <= de_s2_q;
            hit_s3_q  <= hit_s2_q;
            rgb_q     <= rgb_d;
            de_out_q  <= de_s3_q;
            hs_dly_q  <= {hs_dly_q[LATENCY-2:0], hsync_in};
            vs_dly_q  <= {vs_dly_q[LATENCY-2:0], vsync_in};
        end
    end

    // Frame detection and cursor blink phase
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vsync_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b0;
        end else begin
            vsync_q      <= vsync_in;
            frame_tick_q <= frame_rise;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
        end
    end

    vga_font_rom u_font_rom (
        .CLK    (CLK),
        .RESET  (RESET),
        .addr_i ({ram_rd_q[WR_CHAR_LSB +: CHAR_W], row_s2_q}),
        .data_o (rom_row)
    );

    assign hsync_out  = hs_dly_q[LATENCY-1];
    assign vsync_out  = vs_dly_q[LATENCY-1];
    assign de_out     = de_out_q;
    assign rgb_out    = rgb_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
Character-mode pixel generator that sits directly downstream of the VGA sync/timing stage. It consumes the timing stage's hsync/vsync, display-enable and pixel-counter outputs, looks up a character cell in an on-chip text RAM and its glyph row in a font ROM, and drives 12-bit RGB to the DAC pins. A bus-side write port updates the text RAM. A frame-counted blinking cursor is also provided.

Parameters:
COLS, 160, text columns (1280 / 8-pixel glyph width)
ROWS, 64, text rows (1024 / 16-pixel glyph height)
ADDR_W, 14, cell address width; must satisfy 2^ADDR_W >= COLS*ROWS
BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
CLK  in  1  pixel clock, 108 MHz
RESET  in  1  synchronous, active-high
hsync_in  in  1  horizontal sync from timing stage; pulse is active low
vsync_in  in  1  vertical sync from timing stage; pulse is active low
hdisp_in  in  1  horizontal display active
vdisp_in  in  1  vertical display active
hpix_in  in  11  horizontal pixel index; 0 outside the display area
vpix_in  in  11  vertical pixel index; 0 outside the display area
wr_en  in  1  text RAM write strobe, one cycle per write
wr_addr  in  ADDR_W  cell index, row*COLS + col
wr_data  in  16  [7:0] char code, [11:8] fg palette index, [15:12] bg palette index
cursor_en  in  1  cursor enable, level
cursor_addr  in  ADDR_W  cursor cell index
hsync_out  out  1  hsync_in delayed by LATENCY
vsync_out  out  1  vsync_in delayed by LATENCY
de_out  out  1  (hdisp_in & vdisp_in) delayed by LATENCY
rgb_out  out  12  {R[3:0],G[3:0],B[3:0]}
frame_tick  out  1  one-cycle pulse on each vsync_in rising edge

Behaviour:
- Reset (RESET=1 at a CLK edge) forces every output and every pipeline register to 0. This covers hsync_out, vsync_out, de_out, rgb_out, frame_tick, the blink counter and the blink phase. Text RAM contents are not cleared.
- LATENCY = 4 cycles, fixed. hsync_out, vsync_out and de_out are delay lines of exactly 4 registers so they stay aligned with rgb_out.
- S1 (cycle n+1): register cell_addr = vpix_in[10:4]*COLS + hpix_in[10:3], the 3-bit pixel column hpix_in[2:0], the 4-bit glyph row vpix_in[3:0], de, and the syncs. Multiply by the constant COLS; the result is truncated to ADDR_W.
- S2 (n+2): synchronous text RAM read data is valid. Register cursor_hit = cursor_en & blink_on & (cell_addr == cursor_addr).
- S3 (n+3): synchronous font ROM read at address {char_code, glyph_row} (12 bits) returns the 8-bit row byte. Bit 7 is the leftmost pixel.
- S4 (n+4): pix = rowbyte[7 - col].
  - Colour index = pix ? fg : bg.
  - If cursor_hit is set, fg and bg are swapped.
  - rgb_out = PALETTE[index] when de is 1, otherwise 12'h000.
- Text RAM is dual-port with 2^ADDR_W words of 16 bits.
  - Write port: a write takes effect at the CLK edge where wr_en=1.
  - Read collision: a read and a write to the same address in the same cycle returns the OLD data (read-first).
  - Writes with wr_addr >= COLS*ROWS are ignored.
- Blink:
  - frame_tick = vsync_in & ~vsync_q.
  - The counter increments on each frame_tick. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
  - blink_on resets to 0, so the cursor is invisible until the first toggle.
- Reset mid-frame: the pipeline flushes. Outputs are 0 for at least 4 cycles after RESET deasserts, then track the inputs with no further state.
- No backpressure: the block accepts one pixel every cycle, always.

Decomposition:
- Package vga_text_pkg holds:
  - LATENCY = 4
  - GLYPH_W = 8, GLYPH_H = 16
  - the 16-entry 12-bit PALETTE constant (CGA-style, index 0 = 12'h000, index 15 = 12'hFFF)
  - field-position constants for wr_data
- Sub-module vga_font_rom: a 4096x8 synchronous ROM initialised from a font file, one cycle read latency.
- The text RAM is inferred inside vga_text_render.

Test Plan:
1. Reset value: hold RESET for 3 cycles with random inputs -> all outputs 0; rgb_out stays 0 for 4 cycles after release.
2. Glyph render and alignment: write addr 0 = 16'h1F41 ('A', fg=15, bg=1); sweep hpix 0..7 at vpix 4 with de=1 -> at cycle +4, rgb_out = 12'hFFF where the 'A' row-4 bit is 1, otherwise PALETTE[1]; de_out, hsync_out and vsync_out equal the inputs delayed exactly 4 cycles.
3. Blanking and addressing: hdisp_in=0 -> rgb_out=0 regardless of RAM contents; write addr 161 (row 1, col 1) and drive hpix=8, vpix=16 -> the cell 161 glyph appears.
4. Cursor blink: cursor_en=1, cursor_addr=0; issue 30 vsync rising edges -> cell 0 colours inverted (bg=15, fg=1); after 30 more edges -> normal; frame_tick is exactly 1 cycle per edge.
5. Collision and range: write addr 5 in the same cycle it is read -> old data rendered, new data on the next frame; wr_addr = 10240 -> RAM unchanged.
6. Reset mid-frame: assert RESET during an active line -> outputs 0 next edge; after release the blink phase is 0 and rendering resumes correctly.
